// File: rtl/vertical_counter.sv
//============================================================================
// Module      : vertical_counter
// Description : Vertical timing stage of the VGA pipeline. Counts lines on
//               the horizontal line-end strobe and produces registered,
//               mutually aligned hsync / vsync / video_on / pixel
//               coordinates plus a one-cycle frame-end strobe.
// Ports       : clock     - system clock, rising edge
//               res       - asynchronous active-low reset
//               line_end  - one-cycle strobe, last pixel of a line
//               h_count   - horizontal pixel count (10 bit)
//               v_count   - current line number, 0..V_TOTAL-1
//               hsync     - registered horizontal sync
//               vsync     - registered vertical sync
//               video_on  - registered visible-area flag
//               pixel_x   - registered h_count, aligned with video_on
//               pixel_y   - registered v_count, aligned with video_on
//               frame_end - one-cycle strobe, first line of a new frame
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module vertical_counter #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic       clock,
  input  logic       res,
  input  logic       line_end,
  input  logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_end
);

  // All timing boundaries as 10-bit unsigned constants.
  localparam logic [9:0] c_h_visible    = 10'(H_VISIBLE);
  localparam logic [9:0] c_h_sync_start = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_h_sync_end   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_h_total      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] c_v_visible    = 10'(V_VISIBLE);
  localparam logic [9:0] c_v_sync_start = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_v_sync_end   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] c_v_last       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0] r_v_count;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic [9:0] r_pixel_x;
  logic [9:0] r_pixel_y;
  logic       r_frame_end;

  logic       w_h_in_range;
  logic       w_hsync_active;
  logic       w_vsync_active;
  logic       w_video_on;

  // Decode from the current h_count and the *current* line register, so the
  // outputs describe the pixel that was presented this cycle. Because the
  // horizontal and vertical counters wrap on the same edge, the pair is
  // always consistent. The explicit range term keeps out-of-range h_count
  // values (>= H_TOTAL) inactive even if the window constants change.
  always_comb begin
    w_h_in_range   = (h_count < c_h_total);
    w_hsync_active = w_h_in_range &&
                     (h_count >= c_h_sync_start) && (h_count < c_h_sync_end);
    w_vsync_active = (r_v_count >= c_v_sync_start) && (r_v_count < c_v_sync_end);
    w_video_on     = w_h_in_range && (h_count < c_h_visible) &&
                     (r_v_count < c_v_visible);
  end

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      r_v_count   <= '0;
      r_hsync     <= ~SYNC_POL;
      r_vsync     <= ~SYNC_POL;
      r_video_on  <= 1'b0;
      r_pixel_x   <= '0;
      r_pixel_y   <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_frame_end <= 1'b0;
      // line_end is trusted on its own; >= (not ==) lets a counter that is
      // somehow beyond the last line recover at the next line end.
      if (line_end) begin
        if (r_v_count >= c_v_last) begin
          r_v_count   <= '0;
          r_frame_end <= 1'b1;
        end else begin
          r_v_count   <= r_v_count + 10'd1;
        end
      end
      r_hsync    <= w_hsync_active ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= w_vsync_active ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_video_on;
      r_pixel_x  <= h_count;
      r_pixel_y  <= r_v_count;
    end
  end

  assign v_count   = r_v_count;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign video_on  = r_video_on;
  assign pixel_x   = r_pixel_x;
  assign pixel_y   = r_pixel_y;
  assign frame_end = r_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_vertical_counter.sv
//============================================================================
// Module      : tb_vertical_counter
// Description : Self-checking bench for vertical_counter. Uses reduced
//               timing parameters so full frames stay short; a scoreboard
//               queue holds the expected outputs for every driven cycle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vertical_counter;

  localparam int   HV  = 16;
  localparam int   HF  = 4;
  localparam int   HS  = 5;
  localparam int   HB  = 3;
  localparam int   HT  = HV + HF + HS + HB;
  localparam int   VV  = 12;
  localparam int   VF  = 3;
  localparam int   VS  = 2;
  localparam int   VB  = 4;
  localparam int   VT  = VV + VF + VS + VB;
  localparam logic POL = 1'b0;

  logic       clk      = 1'b0;
  logic       res_n    = 1'b0;
  logic       line_end = 1'b0;
  logic [9:0] h_count  = '0;
  logic [9:0] v_count;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       frame_end;

  vertical_counter #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .clock    (clk),
    .res      (res_n),
    .line_end (line_end),
    .h_count  (h_count),
    .v_count  (v_count),
    .hsync    (hsync),
    .vsync    (vsync),
    .video_on (video_on),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int hs;
    int vs;
    int vo;
    int px;
    int py;
    int fe;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_v      = 0;   // model line counter
  int cnt_hs   = 0;   // hsync-active samples in current line
  int cnt_vs   = 0;   // vsync-active samples in current frame
  int cnt_vo   = 0;   // video_on samples in current frame
  int cnt_fe   = 0;   // frame_end samples in current frame

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the expected registered outputs, then
  // pop and compare one sample after the edge.
  task automatic step(input int h, input bit le);
    exp_t e;
    bit   hs_act;
    bit   vs_act;
    h_count  = 10'(h);
    line_end = le;
    hs_act = (h >= HV + HF) && (h < HV + HF + HS);
    vs_act = (m_v >= VV + VF) && (m_v < VV + VF + VS);
    e.hs = hs_act ? int'(POL) : int'(!POL);
    e.vs = vs_act ? int'(POL) : int'(!POL);
    e.vo = ((h < HV) && (m_v < VV)) ? 1 : 0;
    e.px = h;
    e.py = m_v;
    e.fe = 0;
    if (le) begin
      if (m_v >= VT - 1) begin
        m_v  = 0;
        e.fe = 1;
      end else begin
        m_v++;
      end
    end
    e.v = m_v;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("v_count",   32'(v_count),   32'(e.v));
      chk("hsync",     32'(hsync),     32'(e.hs));
      chk("vsync",     32'(vsync),     32'(e.vs));
      chk("video_on",  32'(video_on),  32'(e.vo));
      chk("pixel_x",   32'(pixel_x),   32'(e.px));
      chk("pixel_y",   32'(pixel_y),   32'(e.py));
      chk("frame_end", 32'(frame_end), 32'(e.fe));
    end
    if (hsync === POL)   cnt_hs++;
    if (vsync === POL)   cnt_vs++;
    if (video_on === 1'b1)  cnt_vo++;
    if (frame_end === 1'b1) cnt_fe++;
  endtask

  task automatic run_line();
    cnt_hs = 0;
    for (int h = 0; h < HT; h++) step(h, h == HT - 1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_v_count"},   32'(v_count),   32'd0);
    chk({tag, "_hsync"},     32'(hsync),     32'(!POL));
    chk({tag, "_vsync"},     32'(vsync),     32'(!POL));
    chk({tag, "_video_on"},  32'(video_on),  32'd0);
    chk({tag, "_pixel_x"},   32'(pixel_x),   32'd0);
    chk({tag, "_pixel_y"},   32'(pixel_y),   32'd0);
    chk({tag, "_frame_end"}, 32'(frame_end), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;

    // Reset held with line_end and h_count toggling.
    for (int i = 0; i < 10; i++) begin
      h_count  = 10'(i * 37);
      line_end = i[0];
      @(posedge clk);
      #1;
      chk_reset_values("rst");
    end

    @(negedge clk);
    line_end = 1'b0;
    res_n    = 1'b1;
    m_v      = 0;

    // Frame 1 plus a few lines into frame 2.
    cnt_vs = 0;
    cnt_vo = 0;
    cnt_fe = 0;
    for (int ln = 0; ln < VT + 3; ln++) begin
      run_line();
      if (ln < VT) chk("hsync_low_per_line", 32'(cnt_hs), 32'(HS));
      if (ln == VT - 1) begin
        chk("vsync_low_per_frame", 32'(cnt_vs), 32'(VS * HT));
        chk("video_on_per_frame",  32'(cnt_vo), 32'(HV * VV));
        chk("frame_end_per_frame", 32'(cnt_fe), 32'd1);
      end
    end

    // Out-of-range h_count: hsync inactive, video_on low, line held.
    v0 = m_v;
    step(HT, 1'b0);
    step(HT + 1, 1'b0);
    step(HV + HF + 1 + 512, 1'b0);
    step(1023, 1'b0);
    chk("oob_v_hold", 32'(v_count), 32'(v0));

    // line_end held three cycles advances three lines.
    v0 = m_v;
    step(0, 1'b1);
    step(1, 1'b1);
    step(2, 1'b1);
    chk("line_end_x3", 32'(v_count), 32'(v0 + 3));

    // Get to line 10, then part way into it.
    while (m_v != 10) run_line();
    for (int h = 0; h <= 8; h++) step(h, 1'b0);

    // Asynchronous reset between edges must act before the next edge.
    #2;
    res_n = 1'b0;
    #1;
    chk_reset_values("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("async_rst_hold");
    @(negedge clk);
    res_n = 1'b1;
    m_v   = 0;
    run_line();
    run_line();
    chk("restart_line", 32'(v_count), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vertical_counter.md
# vertical_counter

Vertical timing stage of the VGA pipeline, directly downstream of `horizontal_counter`. It consumes the horizontal line-end strobe and the horizontal pixel count. It maintains the line counter and produces registered, mutually aligned hsync, vsync, video_on, pixel coordinates and a frame-end strobe for the pixel generator and the VGA pins. The default parameters give 640x480 at 60 Hz timing (800x525 total).

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum of the four H_* parameters = 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum of the four V_* parameters = 525
- SYNC_POL, 0, active level of hsync and vsync (0 = active-low)

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- res  in  1  reset, asynchronous, active-low
- line_end  in  1  one-cycle strobe from `horizontal_counter`, high in the cycle where h_count = H_TOTAL-1
- h_count  in  10  current horizontal pixel count from `horizontal_counter`
- v_count  out  10  current line number, 0..V_TOTAL-1
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- video_on  out  1  registered visible-area flag
- pixel_x  out  10  registered copy of h_count, aligned with video_on
- pixel_y  out  10  registered copy of v_count, aligned with video_on
- frame_end  out  1  one-cycle strobe; the first line of a new frame has started

## Operation
- Line counter (v_count):
  - On a rising edge with line_end=1:
    - if v_count >= V_TOTAL-1, v_count <= 0 and frame_end <= 1;
    - otherwise v_count <= v_count+1 and frame_end <= 0.
  - On any rising edge with line_end=0: v_count holds and frame_end <= 0.
- The block trusts line_end alone. It does not cross-check line_end against h_count.
- Output stage: on every rising edge, the registered outputs take values computed from the current h_count and the current v_count register (before that same edge updates v_count):
  - hsync = SYNC_POL when H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise ~SYNC_POL.
  - vsync = SYNC_POL when V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491); otherwise ~SYNC_POL.
  - video_on = (h_count < H_VISIBLE) && (v_count < V_VISIBLE).
  - pixel_x = h_count; pixel_y = v_count.
- Out-of-range h_count (>= H_TOTAL): hsync inactive and video_on=0. The values pass through to pixel_x unchanged.
- All comparisons are unsigned, 10-bit. Parameter sums must not exceed 1023; no saturation logic exists.

## Timing
- Reset (res=0), asynchronous, takes effect immediately:
  - v_count=0, pixel_x=0, pixel_y=0;
  - video_on=0, frame_end=0;
  - hsync=vsync=~SYNC_POL (high by default).
- Release of reset is synchronous to the next rising edge. The first frame starts at line 0.
- Latency: hsync/vsync/video_on/pixel_x/pixel_y lag h_count by exactly 1 clock. All five are mutually aligned.
- v_count and h_count wrap on the same edge, because `horizontal_counter` wraps on the edge where line_end=1. The output stage therefore never sees a mixed old/new line.
- frame_end is high for exactly one clock: the cycle after the edge where v_count wrapped to 0.
- Reset asserted mid-frame: all outputs return to reset values immediately. Counting restarts from line 0.
- line_end held high for N consecutive cycles: v_count advances N times. This is a misuse case but has defined behaviour.

## Test plan
- Reset: hold res=0 for 10 clocks with line_end toggling -> v_count=0, hsync=vsync=1, video_on=0, frame_end=0 throughout.
- Line stepping: release reset, then pulse line_end once every 800 clocks with h_count sweeping 0..799 -> v_count steps 0,1,2,…. hsync is low for exactly 96 clocks per line, starting 1 clock after h_count=656.
- Frame wrap: run 525 lines -> v_count goes 524 -> 0. frame_end is high for a single clock after that edge. vsync is low during lines 490-491 only (1600 clocks).
- Visible area: check video_on across one frame -> high iff pixel_x<640 and pixel_y<480, i.e. 640 clocks per line for lines 0..479 only. Expect 307200 high cycles per frame.
- Mid-frame reset: assert res=0 asynchronously at line 300 with h_count=400 -> outputs reset within the same cycle, before the next edge. After release, v_count restarts at 0.
- Boundaries: drive h_count=800..1023 with line_end=0 -> hsync=1, video_on=0, v_count unchanged. Drive line_end high for 3 consecutive cycles -> v_count advances by 3.
